// File: rtl/bus_memory_responder.sv
// Word-addressed SRAM target on the Gecko5 shared bus: single/burst reads and
// writes with byte enables, error response for misaligned or window-crossing requests.
module bus_memory_responder #(
    parameter logic [31:0] BASE_ADDRESS    = 32'h4000_0000,
    parameter int          ADDR_WORDS_LOG2 = 10,
    parameter int          WAIT_STATES     = 0
) (
    input  logic        system_clock,
    input  logic        system_reset_n,
    input  logic [31:0] address_dataIN,
    input  logic [3:0]  byte_enableIN,
    input  logic [7:0]  burst_sizeIN,
    input  logic        read_n_writeIN,
    input  logic        begin_transactionIN,
    input  logic        end_transactionIN,
    input  logic        data_validIN,
    input  logic        busyIN,
    output logic [31:0] address_dataOUT,
    output logic        data_validOUT,
    output logic        end_transactionOUT,
    output logic        busyOUT,
    output logic        errorOUT
);

    localparam int AW    = ADDR_WORDS_LOG2;
    localparam int WORDS = 1 << AW;
    localparam logic [AW+8:0] LAST_WORD = (AW+9)'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, ERR, END} state_t;

    logic [31:0]   mem [WORDS];
    state_t        state;
    logic [AW-1:0] ptr;
    logic [7:0]    beat_cnt;
    logic [3:0]    be_q;
    logic [3:0]    wait_cnt;
    logic          wr_done;
    logic [31:0]   rd_data_p1;
    logic          vld_p1;
    logic          end_q;
    logic          busy_q;
    logic          err_q;

    logic          selected;
    logic          bad_request;
    logic [AW+8:0] last_idx;
    logic          wr_beat;

    assign selected    = address_dataIN[31:AW+2] == BASE_ADDRESS[31:AW+2];
    assign last_idx    = {9'd0, address_dataIN[AW+1:2]} + {{(AW+1){1'b0}}, burst_sizeIN};
    assign bad_request = (address_dataIN[1:0] != 2'b00) || (last_idx > LAST_WORD);
    // A write beat never lands once the master aborts or the burst is already complete.
    assign wr_beat     = (state == WRITE) && data_validIN && !busy_q && !wr_done
                         && !end_transactionIN;

    always_ff @(posedge system_clock) begin
        if (wr_beat) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[ptr][8*i +: 8] <= address_dataIN[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            beat_cnt   <= '0;
            be_q       <= '0;
            wait_cnt   <= '0;
            wr_done    <= 1'b0;
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
            end_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            end_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    busy_q     <= 1'b0;
                    vld_p1     <= 1'b0;
                    rd_data_p1 <= '0;
                    if (begin_transactionIN && selected) begin
                        ptr      <= address_dataIN[AW+1:2];
                        beat_cnt <= burst_sizeIN;
                        be_q     <= byte_enableIN;
                        wr_done  <= 1'b0;
                        if (bad_request) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end else if (read_n_writeIN) begin
                            state <= READ;
                        end else begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (end_transactionIN && !wr_done) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (wr_beat) begin
                        ptr      <= ptr + 1'b1;
                        beat_cnt <= beat_cnt - 8'd1;
                        busy_q   <= (WAIT_STATES != 0);
                        wait_cnt <= 4'(WAIT_STATES);
                        if (beat_cnt == 8'd0) begin
                            wr_done <= 1'b1;
                            if (WAIT_STATES == 0) state <= IDLE;
                        end
                    end else if (busy_q) begin
                        // Wait states after the final beat still run before releasing the bus.
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            busy_q <= 1'b0;
                            if (wr_done) state <= IDLE;
                        end
                    end
                end
                READ: begin
                    // Memory read stage feeding the registered output stage.
                    if (end_transactionIN) begin
                        state      <= IDLE;
                        vld_p1     <= 1'b0;
                        rd_data_p1 <= '0;
                    end else if (!vld_p1) begin
                        rd_data_p1 <= mem[ptr];
                        vld_p1     <= 1'b1;
                        ptr        <= ptr + 1'b1;
                    end else if (!busyIN) begin
                        if (beat_cnt == 8'd0) begin
                            state      <= END;
                            end_q      <= 1'b1;
                            vld_p1     <= 1'b0;
                            rd_data_p1 <= '0;
                        end else begin
                            beat_cnt   <= beat_cnt - 8'd1;
                            rd_data_p1 <= mem[ptr];
                            ptr        <= ptr + 1'b1;
                        end
                    end
                end
                ERR: begin
                    state <= END;
                    end_q <= 1'b1;
                end
                END: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign address_dataOUT    = rd_data_p1;
    assign data_validOUT      = vld_p1;
    assign end_transactionOUT = end_q;
    assign busyOUT            = busy_q;
    assign errorOUT           = err_q;

endmodule
